alu_share_sched: RTL and testbench

- Time-shares one 4-bit arithmetic unit among NREQ requesters. The unit supports add/sub, ordered pair, multiply and divide.
- Round-robin arbitration with a request/grant handshake. Operands are latched on grant.
- Single-cycle ops complete in one EXEC cycle. Divide is a BITS-cycle iterative restoring divider, so the wide combinational divider is not replicated per requester.
- Sits between switch/button front-ends (or other masters) and the LED/result display logic.

---
 rtl/alu_share_sched_if.sv | 42 ++++
 rtl/alu_share_sched.sv | 189 ++++++++++++++++++
 tb/tb_alu_share_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_sched_if.sv
// Request/grant and result bundle for the shared 4-bit ALU.
// With ALU_STATS_EN defined the bundle also carries the op and div-zero counters.
interface alu_share_sched_if #(
    parameter int BITS = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [BITS*NREQ-1:0] a;
    logic [BITS*NREQ-1:0] b;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [2*BITS-1:0]    res;
    logic                 div_zero;
`ifdef ALU_STATS_EN
    logic [15:0]          op_count;
    logic [7:0]           div_zero_count;

    modport master (
        output req, op, a, b,
        input  gnt, busy, res_valid, res_id, res, div_zero,
        input  op_count, div_zero_count
    );
    modport slave (
        input  req, op, a, b,
        output gnt, busy, res_valid, res_id, res, div_zero,
        output op_count, div_zero_count
    );
`else
    modport master (
        output req, op, a, b,
        input  gnt, busy, res_valid, res_id, res, div_zero
    );
    modport slave (
        input  req, op, a, b,
        output gnt, busy, res_valid, res_id, res, div_zero
    );
`endif
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin time-shared ALU: add/sub, ordered pair, multiply, iterative divide.
// Optional ALU_STATS_EN adds saturating op_count and div_zero_count outputs.
module alu_share_sched #(
    parameter int BITS = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic               clk,
    input logic               rst,
    alu_share_sched_if.slave  bus
);
    localparam int RW = 2 * BITS;
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [1:0]     op_q, op_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  res_q, res_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic           dz_q, dz_d;

    logic [IDW-1:0] idx;
    logic [IDW-1:0] win;
    logic           found;
    logic [NREQ-1:0] gnt;
    logic [RW-1:0]  alu_res;
    logic [BITS:0]  trial;
    logic           ge;
    logic [BITS-1:0] rem_nx;

    // First set request at or after ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        unique case (op_q)
            2'd0: alu_res = {BITS'(a_q + b_q), BITS'(a_q - b_q)};
            2'd1: alu_res = (a_q > b_q) ? {b_q, a_q} : {a_q, b_q};
            2'd2: alu_res = RW'(a_q) * RW'(b_q);
            default: alu_res = '0;
        endcase
    end

    // Trial is one bit wider than the remainder so the compare never wraps
    always_comb begin
        trial  = {rem_q, quo_q[BITS-1]};
        ge     = (trial >= {1'b0, b_q});
        rem_nx = ge ? BITS'(trial - {1'b0, b_q}) : trial[BITS-1:0];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rid_d   = rid_q;
        dz_d    = dz_q;
        gnt     = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt     = NREQ'(1) << win;
                    op_d    = bus.op[2*win +: 2];
                    a_d     = bus.a[BITS*win +: BITS];
                    b_d     = bus.b[BITS*win +: BITS];
                    id_d    = win;
                    ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == 2'd3) begin
                    rem_d   = '0;
                    quo_d   = a_q;
                    cnt_d   = CW'(BITS - 1);
                    state_d = DIV;
                end else begin
                    res_d   = alu_res;
                    rid_d   = id_q;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DIV: begin
                rem_d = rem_nx;
                quo_d = {quo_q[BITS-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    res_d   = {quo_q[BITS-2:0], ge, rem_nx};
                    rid_d   = id_q;
                    dz_d    = (b_q == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rid_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rid_q   <= rid_d;
            dz_q    <= dz_d;
        end
    end

    // Grant is combinational on req, so hold it off while reset is asserted
    assign bus.gnt       = rst ? '0 : gnt;
    assign bus.busy      = !rst && ((state_q != IDLE) || (gnt != '0));
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_id    = rid_q;
    assign bus.res       = res_q;
    assign bus.div_zero  = dz_q;

`ifdef ALU_STATS_EN
    logic [15:0] opc_q, opc_d;
    logic [7:0]  dzc_q, dzc_d;

    always_comb begin
        opc_d = opc_q;
        dzc_d = dzc_q;
        if (state_q == DONE) begin
            if (opc_q != 16'hFFFF) opc_d = opc_q + 1'b1;
            if (dz_q && dzc_q != 8'hFF) dzc_d = dzc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opc_q <= '0;
            dzc_q <= '0;
        end else begin
            opc_q <= opc_d;
            dzc_q <= dzc_d;
        end
    end

    assign bus.op_count       = opc_q;
    assign bus.div_zero_count = dzc_q;
`endif
endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_alu_share_sched;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_sched_if #(.BITS(4), .NREQ(4), .IDW(2)) bus ();

    alu_share_sched #(.BITS(4), .NREQ(4), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: idle or counting down to the result cycle
    int m_left = 0;
    int m_ptr  = 0;
    int mk;
    logic [7:0] m_res, p_res;
    logic [1:0] m_id, p_id;
    logic       m_dz, p_dz;
    logic [3:0] e_gnt;
    logic       e_busy, e_rv;
    logic [1:0] mo;
    logic [3:0] ma, mb, lo, hi;

    always @(negedge clk) begin
        e_gnt  = '0;
        e_busy = 1'b0;
        e_rv   = 1'b0;
        if (rst) begin
            m_left = 0;
            m_ptr  = 0;
            m_res  = '0;
            m_id   = '0;
            m_dz   = 1'b0;
        end else if (m_left == 0) begin
            for (int i = 0; i < 4; i++) begin
                mk = (m_ptr + i) % 4;
                if (e_gnt == 0 && bus.req[mk]) begin
                    e_gnt  = 4'(1 << mk);
                    e_busy = 1'b1;
                    mo = bus.op[2*mk +: 2];
                    ma = bus.a[4*mk +: 4];
                    mb = bus.b[4*mk +: 4];
                    lo = (ma < mb) ? ma : mb;
                    hi = (ma < mb) ? mb : ma;
                    p_id = 2'(mk);
                    p_dz = 1'b0;
                    case (mo)
                        2'd0: p_res = {4'(ma + mb), 4'(ma - mb)};
                        2'd1: p_res = {lo, hi};
                        2'd2: p_res = 8'(int'(ma) * int'(mb));
                        default: begin
                            if (mb == 0) begin
                                p_res = {4'hF, ma};
                                p_dz  = 1'b1;
                            end else begin
                                p_res = {4'(ma / mb), 4'(ma % mb)};
                            end
                        end
                    endcase
                    m_left = (mo == 2'd3) ? 6 : 2;
                    m_ptr  = (mk + 1) % 4;
                end
            end
        end else begin
            e_busy = 1'b1;
            if (m_left == 1) begin
                e_rv  = 1'b1;
                m_res = p_res;
                m_id  = p_id;
                m_dz  = p_dz;
            end
            m_left--;
        end
        chk("cyc_gnt", bus.gnt, e_gnt);
        chk("cyc_busy", bus.busy, e_busy);
        chk("cyc_res_valid", bus.res_valid, e_rv);
        chk("cyc_res", bus.res, m_res);
        chk("cyc_res_id", bus.res_id, m_id);
        chk("cyc_div_zero", bus.div_zero, m_dz);
    end

    task automatic do_op(input int k, input logic [1:0] o, input logic [3:0] av,
                         input logic [3:0] bv, input logic [7:0] er,
                         input logic edz, input int elat);
        int  lat;
        bit  seen;
        bus.req = 4'(1 << k);
        bus.op[2*k +: 2] = o;
        bus.a[4*k +: 4]  = av;
        bus.b[4*k +: 4]  = bv;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.gnt != 0) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("op_gnt", bus.gnt, 32'(1 << k));
        @(posedge clk); #1;
        bus.req = '0;
        bus.op  = 8'($urandom);
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        lat  = 0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            lat++;
            if (bus.res_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("op_latency", 32'(lat), 32'(elat));
        chk("op_res", bus.res, er);
        chk("op_res_id", bus.res_id, 32'(k));
        chk("op_div_zero", bus.div_zero, edz);
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int exp_g[5] = '{1, 2, 4, 8, 1};
    int gi, ri, lowrun, maxlow;
    bit started, seen;

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.op  = '0;
        bus.a   = '0;
        bus.b   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res", bus.res, 0);
        @(posedge clk); #1;

        do_op(0, 2'd0, 4'd9, 4'd3, 8'hC6, 1'b0, 2);
        do_op(1, 2'd2, 4'd15, 4'd15, 8'hE1, 1'b0, 2);
        do_op(1, 2'd1, 4'd9, 4'd3, 8'h39, 1'b0, 2);
        do_op(0, 2'd3, 4'd13, 4'd4, 8'h31, 1'b0, 6);
        do_op(0, 2'd3, 4'd13, 4'd0, 8'hFD, 1'b1, 6);

        // All four requesting continuously after reset
        pulse_rst();
        bus.req = 4'hF;
        bus.op  = '0;
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        gi = 0; ri = 0; lowrun = 0; maxlow = 0; started = 0;
        for (int n = 0; n < 80 && ri < 5; n++) begin
            @(negedge clk);
            if (bus.gnt != 0 && gi < 5) begin
                chk("rr_gnt", bus.gnt, 32'(exp_g[gi]));
                gi++;
            end
            if (bus.res_valid) begin
                chk("rr_res_id", bus.res_id, 32'(ri % 4));
                ri++;
            end
            if (started) begin
                if (bus.busy) lowrun = 0;
                else begin
                    lowrun++;
                    if (lowrun > maxlow) maxlow = lowrun;
                end
            end
            if (bus.gnt != 0) started = 1;
            if (ri < 5) begin
                @(posedge clk); #1;
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
        end
        bus.req = '0;
        chk("rr_count", 32'(ri), 5);
        chk("rr_busy_gap", 32'(maxlow <= 1), 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a divide
        pulse_rst();
        bus.req = 4'b0001;
        bus.op[1:0] = 2'd3;
        bus.a[3:0]  = 4'd15;
        bus.b[3:0]  = 4'd1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.gnt != 0) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("mid_gnt", bus.gnt, 1);
        @(posedge clk); #1;
        bus.req = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_res", bus.res, 0);
        chk("mid_rst_id", bus.res_id, 0);
        chk("mid_rst_dz", bus.div_zero, 0);
        bus.req = 4'b1001;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_gnt", bus.gnt, 1);
        @(posedge clk); #1;
        bus.req = '0;
        repeat (10) @(posedge clk);
        #1;

        for (int n = 0; n < 3000; n++) begin
            bus.req = 4'($urandom_range(0, 15));
            bus.op  = 8'($urandom);
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.req = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
